// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, round constants and byte-level AES helpers
// used by the round controller, the key-step block and the round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam int NUM_ROUNDS = 10;

  // Round constants for rounds 1..10 (entry 0 belongs to round 1)
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, one 16-entry row per high nibble of the input byte
  localparam logic [0:15][127:0] SBOX_ROWS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    logic [127:0] shifted;
    row     = SBOX_ROWS[b[7:4]];
    shifted = row >> {4'd15 - b[3:0], 3'b000};
    return shifted[7:0];
  endfunction

  // Round number 1..10 maps onto its constant; anything else yields zero
  function automatic logic [7:0] rcon_for_round(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (int'(rnd) == i + 1) r = RCON[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i of the 128-bit block lives at [127-8*i -: 8]; columns are bytes 4c..4c+3
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_final_round.sv
// aes_final_round: the last AES round, which omits MixColumns.
module aes_final_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] next_state
);

  assign next_state = shift_rows(sub_bytes(state)) ^ round_key;

endmodule

// File: rtl/aes_full_round.sv
// aes_full_round: one complete AES round (SubBytes, ShiftRows, MixColumns,
// AddRoundKey), purely combinational.
module aes_full_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] next_state
);

  assign next_state = mix_columns(shift_rows(sub_bytes(state))) ^ round_key;

endmodule

// File: rtl/aes_key_step.sv
// aes_key_step: combinational AES-128 key expansion step, producing the next
// round key from the current one and the round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w4, w5, w6, w7;
  logic [31:0] rot;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  assign w4 = w0 ^ sub_word(rot) ^ {rcon, 24'h000000};
  assign w5 = w4 ^ w1;
  assign w6 = w5 ^ w2;
  assign w7 = w6 ^ w3;

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption controller. Accepts one block
// and key, runs the key addition plus 10 rounds one per clock on a shared
// datapath with on-the-fly key expansion, then presents the ciphertext.
// Optional feature: define AES_ABORT_EN to add an 'abort' input that cancels
// a block in ROUND or DONE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS != aes_pkg::NUM_ROUNDS) begin : g_bad_num_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10 for AES-128");
  end

  aes_state_e   fsm_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] rk_n;
  logic [127:0] full_out;
  logic [127:0] final_out;
  logic [7:0]   rcon;
  logic         cancel;

`ifdef AES_ABORT_EN
  assign cancel = abort;
`else
  assign cancel = 1'b0;
`endif

  // round_idx doubles as the round counter, so it selects the round constant
  assign rcon = rcon_for_round(round_idx);

  aes_key_step u_key_step (
    .key      (rk_q),
    .rcon     (rcon),
    .next_key (rk_n)
  );

  aes_full_round u_full_round (
    .state      (state_q),
    .round_key  (rk_n),
    .next_state (full_out)
  );

  aes_final_round u_final_round (
    .state      (state_q),
    .round_key  (rk_n),
    .next_state (final_out)
  );

  // Block sequencer: accept in IDLE, one round per clock in ROUND, hold result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rk_q      <= '0;
      round_idx <= 4'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q   <= in_data ^ in_key;
            rk_q      <= in_key;
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm_q     <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          if (cancel) begin
            round_idx <= 4'd0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm_q     <= IDLE;
          end else if (round_idx == LAST_ROUND) begin
            state_q   <= final_out;
            rk_q      <= rk_n;
            out_data  <= final_out;
            out_valid <= 1'b1;
            fsm_q     <= DONE;
          end else begin
            state_q   <= full_out;
            rk_q      <= rk_n;
            round_idx <= round_idx + 4'd1;
          end
        end
        DONE: begin
          if (cancel || out_ready) begin
            out_valid <= 1'b0;
            round_idx <= 4'd0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm_q     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          round_idx <= 4'd0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          fsm_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl. Known-answer
// vectors from a table, directed multi-cycle sequences, and randomized blocks
// scored against a byte-array AES-128 reference model built from GF(2^8)
// arithmetic. Abort sequences are included when AES_ABORT_EN is defined.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_ABORT_EN
    .abort     (abort),
`endif
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int out_count    = 0;
  int cyc          = 0;

  logic [127:0] exp_q[$];
  int           accept_cyc[$];
  logic [7:0]   sbox_tab [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [2];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse followed by the affine transform
  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, b);
      end
      sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        for (int i = 0; i < 16; i++) s[i] = t[i];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
              t[r+4*c] = gmul(8'h02, s[r+4*c]) ^ gmul(8'h03, s[(r+1)%4+4*c]) ^
                         s[(r+2)%4+4*c] ^ s[(r+3)%4+4*c];
          for (int i = 0; i < 16; i++) s[i] = t[i];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one block for exactly one edge, then scramble the bus
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    stepCycle();
    in_valid = 1'b0;
    in_data  = rand128();
    in_key   = rand128();
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin stepCycle(); n++; end
    checkOutput({tag, "_ready_wait"}, 128'(in_ready), 128'd1);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin stepCycle(); n++; end
    checkOutput({tag, "_valid_wait"}, 128'(out_valid), 128'd1);
  endtask

  // Full block: latency, round_idx sequence, ciphertext and handshake return
  task automatic runBlock(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] ct, input string tag);
    int lat;
    bit idx_ok;
    waitReady(tag);
    applyStimulus(key, pt);
    checkOutput({tag, "_busy"}, 128'(busy), 128'd1);
    lat    = 0;
    idx_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (round_idx != 4'(lat + 1)) idx_ok = 1'b0;
      stepCycle();
      lat++;
    end
    if (round_idx != 4'd10) idx_ok = 1'b0;
    checkOutput({tag, "_latency"}, 128'(lat), 128'd10);
    checkOutput({tag, "_round_idx_seq"}, 128'(idx_ok), 128'd1);
    checkOutput({tag, "_ct"}, out_data, ct);
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after_hs"}, 128'(in_ready), 128'd1);
    checkOutput({tag, "_out_valid_dropped"}, 128'(out_valid), 128'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: what is seen here happens on the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end
`ifdef AES_ABORT_EN
    else if (abort && busy) begin
      exp_q.delete();
    end
`endif
    else begin
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0)
          checkOutput("output_without_input", 128'(out_valid), 128'd0);
        else
          checkOutput("scoreboard_ct", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(aes_ref(in_key, in_data));
        accept_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  base, sent, n;
    bit  ok_a, ok_b, accepted_now;

    build_sbox();
    vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
`ifdef AES_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) stepCycle();
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_out_data", out_data, 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_round_idx", 128'(round_idx), 128'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("in_ready_after_reset", 128'(in_ready), 128'd1);

    $display("[TB] known-answer vectors");
    for (int i = 0; i < 2; i++) begin
      runBlock(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("kat%0d", i));
    end

    $display("[TB] output backpressure");
    waitReady("bp");
    applyStimulus(C1_KEY, C1_PT);
    waitValid("bp");
    checkOutput("bp_first_ct", out_data, C1_CT);
    ok_a = 1'b1;
    ok_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (!out_valid || out_data != C1_CT) ok_a = 1'b0;
      if (in_ready) ok_b = 1'b0;
    end
    checkOutput("bp_data_stable", 128'(ok_a), 128'd1);
    checkOutput("bp_in_ready_low", 128'(ok_b), 128'd1);
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("bp_in_ready_after_pulse", 128'(in_ready), 128'd1);

    $display("[TB] back-to-back with in_valid held high");
    accept_cyc.delete();
    base      = out_count;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = rand128();
      in_key  = rand128();
      stepCycle();
    end
    in_valid = 1'b0;
    n = 0;
    while (!(in_ready && !busy) && n < 60) begin stepCycle(); n++; end
    out_ready = 1'b0;
    checkOutput("b2b_accepts", 128'(accept_cyc.size() >= 2), 128'd1);
    if (accept_cyc.size() >= 2)
      checkOutput("b2b_period", 128'(accept_cyc[1] - accept_cyc[0]), 128'd12);
    checkOutput("b2b_outputs", 128'(out_count - base), 128'(accept_cyc.size()));

    $display("[TB] reset during round 5");
    waitReady("rst5");
    applyStimulus(C1_KEY, C1_PT);
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin stepCycle(); n++; end
    checkOutput("rst5_reached_round5", 128'(round_idx), 128'd5);
    rst = 1'b1;
    stepCycle();
    checkOutput("rst5_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst5_round_idx", 128'(round_idx), 128'd0);
    checkOutput("rst5_busy", 128'(busy), 128'd0);
    checkOutput("rst5_in_ready_in_reset", 128'(in_ready), 128'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("rst5_in_ready_after", 128'(in_ready), 128'd1);
    runBlock(C1_KEY, C1_PT, C1_CT, "rst5_fresh");

    $display("[TB] randomized blocks with random backpressure");
    base    = out_count;
    sent    = 0;
    n       = 0;
    in_key  = rand128();
    in_data = rand128();
    while ((sent < 6 || out_count - base < 6) && n < 2000) begin
      in_valid     = (sent < 6) && ($urandom_range(0, 3) != 0);
      out_ready    = 1'($urandom_range(0, 1));
      accepted_now = in_valid && in_ready;
      stepCycle();
      n++;
      if (accepted_now) begin
        sent++;
        in_key  = rand128();
        in_data = rand128();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("random_no_timeout", 128'(n < 2000), 128'd1);
    checkOutput("random_outputs", 128'(out_count - base), 128'd6);

`ifdef AES_ABORT_EN
    $display("[TB] abort sequences");
    waitReady("ab3");
    applyStimulus(C1_KEY, C1_PT);
    n = 0;
    while (round_idx != 4'd3 && n < 20) begin stepCycle(); n++; end
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("ab3_out_valid", 128'(out_valid), 128'd0);
    checkOutput("ab3_busy", 128'(busy), 128'd0);
    checkOutput("ab3_round_idx", 128'(round_idx), 128'd0);
    checkOutput("ab3_in_ready", 128'(in_ready), 128'd1);
    ok_a = 1'b1;
    repeat (15) begin stepCycle(); if (out_valid) ok_a = 1'b0; end
    checkOutput("ab3_no_output", 128'(ok_a), 128'd1);

    waitReady("abd");
    applyStimulus(C1_KEY, C1_PT);
    waitValid("abd");
    abort     = 1'b1;
    out_ready = 1'b1;
    stepCycle();
    abort     = 1'b0;
    out_ready = 1'b0;
    checkOutput("abd_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abd_busy", 128'(busy), 128'd0);
    checkOutput("abd_in_ready", 128'(in_ready), 128'd1);

    waitReady("abi");
    abort = 1'b1;
    applyStimulus(vecs[1].key, vecs[1].pt);
    abort = 1'b0;
    checkOutput("abi_accepted", 128'(busy), 128'd1);
    waitValid("abi");
    checkOutput("abi_ct", out_data, vecs[1].ct);
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
`endif

    repeat (2) stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
